wptr_full_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO, in the write clock domain. It mirrors the read-side pointer handler. It advances binary and Gray write pointers on accepted writes and derives a registered full flag from the synchronized Gray read pointer. It also provides an almost-full flag, a fill level and a sticky overflow error, which feed the FIFO memory write port and the upstream producer.

---
 rtl/asyn_fifo_pkg.sv | 23 ++
 rtl/gray2bin.sv | 17 +
 rtl/wptr_full_ctrl.sv | 79 +++++++
 tb/tb_wptr_full_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/asyn_fifo_pkg.sv
// Shared constants and pointer-code helpers for both sides of the asynchronous FIFO.
package asyn_fifo_pkg;

  localparam int unsigned PTR_WIDTH    = 3;
  localparam int unsigned DEPTH        = 2 ** PTR_WIDTH;
  localparam int unsigned AFULL_THRESH = 6;

  typedef logic [PTR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter, width-parameterised for reuse on either FIFO side.
module gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    // Each binary bit is the XOR of all Gray bits at and above it.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and flag controller for the asynchronous FIFO: pointers,
// registered full / almost-full / level, and a sticky overflow error.
module wptr_full_ctrl
  import asyn_fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH    = asyn_fifo_pkg::PTR_WIDTH,
  parameter int unsigned AFULL_THRESH = asyn_fifo_pkg::AFULL_THRESH
) (
  input  logic               wclk_i,
  input  logic               wrst_i,
  input  logic               w_en_i,
  input  logic               ovf_clr_i,
  input  logic [PTR_WIDTH:0] g_rptr_sync_i,
  output logic               wr_fire_o,
  output logic [PTR_WIDTH:0] b_wptr_o,
  output logic [PTR_WIDTH:0] g_wptr_o,
  output logic               full_o,
  output logic               almost_full_o,
  output logic [PTR_WIDTH:0] level_o,
  output logic               overflow_o
);

  localparam logic [PTR_WIDTH:0] AFULL_LVL = (PTR_WIDTH+1)'(AFULL_THRESH);

  logic [PTR_WIDTH:0] r_b_wptr;
  logic [PTR_WIDTH:0] r_g_wptr;
  logic               r_full;
  logic               r_afull;
  logic [PTR_WIDTH:0] r_level;
  logic               r_ovf;

  logic               w_fire;
  logic [PTR_WIDTH:0] w_b_next;
  logic [PTR_WIDTH:0] w_g_next;
  logic [PTR_WIDTH:0] w_b_rptr;
  logic [PTR_WIDTH:0] w_g_full_cmp;
  logic [PTR_WIDTH:0] w_level_next;

  gray2bin #(.WIDTH(PTR_WIDTH + 1)) u_rptr_g2b (
    .gray_i (g_rptr_sync_i),
    .bin_o  (w_b_rptr)
  );

  always_comb begin
    w_fire       = w_en_i & ~r_full;
    w_b_next     = r_b_wptr + {{PTR_WIDTH{1'b0}}, w_fire};
    w_g_next     = (w_b_next >> 1) ^ w_b_next;
    // Full when write Gray equals read Gray with the top two bits inverted.
    w_g_full_cmp = {~g_rptr_sync_i[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync_i[PTR_WIDTH-2:0]};
    w_level_next = w_b_next - w_b_rptr;
  end

  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      r_b_wptr <= '0;
      r_g_wptr <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_b_wptr <= w_b_next;
      r_g_wptr <= w_g_next;
      r_full   <= (w_g_next == w_g_full_cmp);
      r_afull  <= (w_level_next >= AFULL_LVL);
      r_level  <= w_level_next;
      r_ovf    <= (w_en_i & r_full) | (r_ovf & ~ovf_clr_i);
    end
  end

  assign wr_fire_o     = w_fire;
  assign b_wptr_o      = r_b_wptr;
  assign g_wptr_o      = r_g_wptr;
  assign full_o        = r_full;
  assign almost_full_o = r_afull;
  assign level_o       = r_level;
  assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl with PTR_WIDTH=3, AFULL_THRESH=6.
module tb_wptr_full_ctrl;

  logic       wclk_i = 1'b0;
  logic       wrst_i;
  logic       w_en_i;
  logic       ovf_clr_i;
  logic [3:0] g_rptr_sync_i;
  logic       wr_fire_o;
  logic [3:0] b_wptr_o;
  logic [3:0] g_wptr_o;
  logic       full_o;
  logic       almost_full_o;
  logic [3:0] level_o;
  logic       overflow_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  bw;

  always #5 wclk_i = ~wclk_i;

  wptr_full_ctrl #(.PTR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .wclk_i        (wclk_i),
    .wrst_i        (wrst_i),
    .w_en_i        (w_en_i),
    .ovf_clr_i     (ovf_clr_i),
    .g_rptr_sync_i (g_rptr_sync_i),
    .wr_fire_o     (wr_fire_o),
    .b_wptr_o      (b_wptr_o),
    .g_wptr_o      (g_wptr_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .level_o       (level_o),
    .overflow_o    (overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk_i);
    #1;
  endtask

  initial begin
    wrst_i = 1'b1; w_en_i = 1'b1; ovf_clr_i = 1'b0; g_rptr_sync_i = 4'd0;
    tick(); tick();
    check("rst_b", b_wptr_o, 0);
    check("rst_g", g_wptr_o, 0);
    check("rst_full", full_o, 0);
    check("rst_afull", almost_full_o, 0);
    check("rst_level", level_o, 0);
    check("rst_ovf", overflow_o, 0);

    // Fill eight entries with the reader parked at zero.
    wrst_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("fill_fire", wr_fire_o, 1);
      tick();
      check("fill_level", level_o, k);
      check("fill_afull", almost_full_o, (k >= 6) ? 1 : 0);
      check("fill_full", full_o, (k == 8) ? 1 : 0);
    end
    check("fill_b", b_wptr_o, 4'b1000);
    check("fill_g", g_wptr_o, 4'b1100);
    check("fill_ovf", overflow_o, 0);

    // Writes while full are refused and flagged.
    for (int k = 0; k < 3; k++) begin
      check("ovf_fire", wr_fire_o, 0);
      tick();
      check("ovf_b", b_wptr_o, 4'b1000);
      check("ovf_flag", overflow_o, 1);
    end
    w_en_i = 1'b0; ovf_clr_i = 1'b1;
    tick();
    check("ovf_clr", overflow_o, 0);
    w_en_i = 1'b1;
    tick();
    check("ovf_set_wins", overflow_o, 1);
    ovf_clr_i = 1'b0; w_en_i = 1'b0;
    tick();
    check("ovf_hold", overflow_o, 1);

    // One entry freed by the reader.
    g_rptr_sync_i = 4'b0001;
    tick();
    check("drain_full", full_o, 0);
    check("drain_level", level_o, 7);
    w_en_i = 1'b1;
    tick();
    check("refill_b", b_wptr_o, 4'b1001);
    check("refill_full", full_o, 1);
    check("refill_level", level_o, 8);

    // Stream with the reader trailing two behind, across the pointer wrap.
    bw = 4'b1001;
    for (int k = 0; k < 20; k++) begin
      g_rptr_sync_i = gray(bw - 4'd1);
      if (k == 0) w_en_i = 1'b0;
      tick();
      if (k == 0) begin
        check("wrap_unfull", full_o, 0);
        w_en_i = 1'b1;
        continue;
      end
      bw = bw + 4'd1;
      check("wrap_b", b_wptr_o, bw);
      check("wrap_g", g_wptr_o, gray(bw));
      check("wrap_level", level_o, 2);
      check("wrap_full", full_o, 0);
      if (bw == 4'd0) check("wrap_g0", g_wptr_o, 4'b0000);
    end
    w_en_i = 1'b0;

    // Fill again, provoke overflow, then reset mid-operation.
    g_rptr_sync_i = gray(bw - 4'd7);
    w_en_i = 1'b1;
    tick();
    check("pre_full", full_o, 1);
    tick();
    check("pre_ovf", overflow_o, 1);
    wrst_i = 1'b1;
    tick();
    check("mrst_b", b_wptr_o, 0);
    check("mrst_g", g_wptr_o, 0);
    check("mrst_full", full_o, 0);
    check("mrst_afull", almost_full_o, 0);
    check("mrst_level", level_o, 0);
    check("mrst_ovf", overflow_o, 0);
    wrst_i = 1'b0; g_rptr_sync_i = 4'd0;
    tick();
    check("post_b", b_wptr_o, 1);
    check("post_level", level_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
